// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit multiplexed seven-segment scanner.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = 2;

    localparam logic [IDX_W-1:0] POS_ONES = 2'd0;
    localparam logic [IDX_W-1:0] POS_TENS = 2'd1;
    localparam logic [IDX_W-1:0] POS_HUND = 2'd2;
    localparam logic [IDX_W-1:0] POS_THOS = 2'd3;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [BCD_W-1:0] thos;
        logic [BCD_W-1:0] hund;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd_digits_t;

    function automatic logic [BCD_W-1:0] digit_at(input bcd_digits_t d,
                                                 input logic [IDX_W-1:0] pos);
        case (pos)
            POS_ONES: return d.ones;
            POS_TENS: return d.tens;
            POS_HUND: return d.hund;
            default:  return d.thos;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; non-decimal codes show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed display driver: frame-synchronous digit update,
// leading-zero blanking, one decimal point, registered anode/cathode outputs.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DP_DIGIT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BCD_W-1:0]      thos,
    input  logic [BCD_W-1:0]      hund,
    input  logic [BCD_W-1:0]      tens,
    input  logic [BCD_W-1:0]      ones,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  dp_en,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int unsigned       CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  DP_POS  = IDX_W'(DP_DIGIT);

    logic [CNT_W-1:0] presc;
    logic [IDX_W-1:0] idx;
    bcd_digits_t      shadow;
    bcd_digits_t      active;
    logic             pending;

    logic             tick_c;
    logic             boundary_c;
    logic             blank_c;
    logic [BCD_W-1:0] cur_digit_c;
    logic [SEG_W-1:0] dec_seg_c;

    assign tick_c      = (presc == CNT_MAX);
    assign boundary_c  = tick_c && (idx == POS_THOS);
    assign cur_digit_c = digit_at(active, idx);

    // Slot timing: prescaler sets the dwell time, idx walks the digits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= POS_ONES;
        end else if (tick_c) begin
            presc <= '0;
            idx   <= idx + IDX_W'(1);
        end else begin
            presc <= presc + CNT_W'(1);
        end
    end

    // Double buffer: a load coincident with a boundary lands in shadow after the
    // boundary has already copied the previous shadow, so it waits one frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (boundary_c && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (load) begin
                shadow  <= {thos, hund, tens, ones};
                pending <= 1'b1;
            end
        end
    end

    // Leading-zero blanking of the digit currently being scanned
    always_comb begin
        blank_c = 1'b0;
        if (blank_lz) begin
            case (idx)
                POS_THOS: blank_c = (active.thos == '0);
                POS_HUND: blank_c = (active.thos == '0) && (active.hund == '0);
                POS_TENS: blank_c = (active.thos == '0) && (active.hund == '0)
                                    && (active.tens == '0);
                default:  blank_c = 1'b0;
            endcase
        end
    end

    seg7_decode u_decode (
        .bcd   (cur_digit_c),
        .seg_c (dec_seg_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary_c;
            if (blank_c) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= dec_seg_c;
                dp  <= !((idx == DP_POS) && dp_en);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan against a cycle-count reference model.
module tb_seg7_scan;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DPD   = 2;
    localparam int unsigned FRAME = 4 * DIV;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] digs     = '0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic        dp_en    = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    seg7_scan #(.REFRESH_DIV(DIV), .DP_DIGIT(DPD)) dut (
        .clk        (clk),
        .reset      (reset),
        .thos       (digs[15:12]),
        .hund       (digs[11:8]),
        .tens       (digs[7:4]),
        .ones       (digs[3:0]),
        .load       (load),
        .blank_lz   (blank_lz),
        .dp_en      (dp_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_pat(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {an, seg, dp} for the slot occupied after n edges since reset
    function automatic logic [11:0] model_out(input int unsigned n, input logic [15:0] act,
                                              input logic blz, input logic dpe);
        int unsigned pos;
        int unsigned lead;
        logic        blanked;
        logic [3:0]  a;
        logic [6:0]  s;
        pos = (n / DIV) % 4;
        if (act[15:12] != 4'd0)     lead = 0;
        else if (act[11:8] != 4'd0) lead = 1;
        else if (act[7:4] != 4'd0)  lead = 2;
        else                        lead = 3;
        blanked = blz && ((pos + lead) >= 4);
        a = 4'hF;
        if (!blanked) a[pos[1:0]] = 1'b0;
        s = blanked ? 7'h7F : seg_pat(4'(act >> (4 * pos)));
        return {a, s, !((pos == DPD) && dpe && !blanked)};
    endfunction

    function automatic logic is_boundary(input int unsigned n);
        return (n % FRAME) == (FRAME - 1);
    endfunction

    int unsigned m_n;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    logic        m_pending;
    logic        m_fd;
    logic [11:0] m_out;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n       <= 0;
            m_shadow  <= '0;
            m_active  <= '0;
            m_pending <= 1'b0;
            m_fd      <= 1'b0;
            m_out     <= 12'hFFF;
        end else begin
            m_out <= model_out(m_n, m_active, blank_lz, dp_en);
            m_fd  <= is_boundary(m_n);
            if (is_boundary(m_n) && m_pending) begin
                m_active  <= m_shadow;
                m_pending <= 1'b0;
            end
            if (load) begin
                m_shadow  <= digs;
                m_pending <= 1'b1;
            end
            m_n <= m_n + 1;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic load_digits(input logic [15:0] d);
        digs = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME && !ok; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if ({an, seg, dp, frame_done} !== 13'b1111_1111111_1_0) begin
            bad++;
            $display("FAIL reset_async: got %b %b %b %b want 1111 1111111 1 0", an, seg, dp, frame_done);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({an, seg, dp, frame_done} !== 13'b1111_1111111_1_0) begin
            bad++;
            $display("FAIL reset_held: got %b %b %b %b want 1111 1111111 1 0", an, seg, dp, frame_done);
        end
        reset = 1'b0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_done} !== {m_out, m_fd}) begin
                bad++;
                $display("FAIL reset_model i=%0d: got %b %b %b %b want %b %b %b %b", i, an, seg, dp,
                         frame_done, m_out[11:8], m_out[7:1], m_out[0], m_fd);
            end
            if (i == 1 || i == DIV) begin
                total++;
                if ({an, seg} !== {4'b1110, 7'b1000000}) begin
                    bad++;
                    $display("FAIL reset_ones_slot i=%0d: got %b %b want 1110 1000000", i, an, seg);
                end
            end
            if (i == DIV + 1) begin
                total++;
                if (an !== 4'b1101) begin
                    bad++;
                    $display("FAIL first_tick: got an=%b want 1101", an);
                end
            end
            total++;
            if (frame_done !== (i == FRAME || i == 2 * FRAME)) begin
                bad++;
                $display("FAIL reset_fd_period i=%0d: got %b want %b", i, frame_done,
                         (i == FRAME || i == 2 * FRAME));
            end
        end
    endtask

    task automatic test_load_midframe();
        bit ok;
        logic [6:0] exp_seg;
        wait_fd(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL load_sync: got no frame_done want frame_done"); end
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_done} !== {m_out, m_fd}) begin
                bad++;
                $display("FAIL load_model i=%0d: got %b %b %b %b want %b %b %b %b", i, an, seg, dp,
                         frame_done, m_out[11:8], m_out[7:1], m_out[0], m_fd);
            end
            if (an === 4'b1110) begin
                total++;
                if (seg !== 7'b1000000) begin
                    bad++;
                    $display("FAIL load_midframe_hold i=%0d: got %b want 1000000", i, seg);
                end
            end
            if (i == 3) begin digs = 16'h9999; load = 1'b1; end
            if (i == 4) load = 1'b0;
            if (i == 5) begin digs = 16'h1234; load = 1'b1; end
            if (i == 6) load = 1'b0;
        end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL load_fd: got %b want 1", frame_done);
        end
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: exp_seg = 7'b0011001;
                4'b1101: exp_seg = 7'b0110000;
                4'b1011: exp_seg = 7'b0100100;
                4'b0111: exp_seg = 7'b1111001;
                default: exp_seg = 7'bxxxxxxx;
            endcase
            total++;
            if (seg !== exp_seg) begin
                bad++;
                $display("FAIL load_slot i=%0d an=%b: got seg=%b want %b", i, an, seg, exp_seg);
            end
            total++;
            if ({an, seg, dp, frame_done} !== {m_out, m_fd}) begin
                bad++;
                $display("FAIL load_model2 i=%0d: got %b %b %b %b want %b %b %b %b", i, an, seg, dp,
                         frame_done, m_out[11:8], m_out[7:1], m_out[0], m_fd);
            end
        end
    endtask

    task automatic test_boundary_load();
        bit ok;
        wait_fd(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bl_sync: got no frame_done want frame_done"); end
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_done} !== {m_out, m_fd}) begin
                bad++;
                $display("FAIL bl_model i=%0d: got %b %b %b %b want %b %b %b %b", i, an, seg, dp,
                         frame_done, m_out[11:8], m_out[7:1], m_out[0], m_fd);
            end
            if (i == 10) begin digs = 16'h1111; load = 1'b1; end
            if (i == 11) load = 1'b0;
            if (i == FRAME - 1) begin digs = 16'h5678; load = 1'b1; end
        end
        @(negedge clk);
        load = 1'b0;
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL bl_fd: got %b want 1", frame_done);
        end
        for (int i = 1; i <= FRAME + 1; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_done} !== {m_out, m_fd}) begin
                bad++;
                $display("FAIL bl_model2 i=%0d: got %b %b %b %b want %b %b %b %b", i, an, seg, dp,
                         frame_done, m_out[11:8], m_out[7:1], m_out[0], m_fd);
            end
            total++;
            if (frame_done !== (i == FRAME)) begin
                bad++;
                $display("FAIL bl_period i=%0d: got %b want %b", i, frame_done, (i == FRAME));
            end
            if (i == 1) begin
                total++;
                if ({an, seg} !== {4'b1110, 7'b1111001}) begin
                    bad++;
                    $display("FAIL bl_old_shadow: got %b %b want 1110 1111001", an, seg);
                end
            end
            if (i == FRAME) begin
                total++;
                if ({an, seg} !== {4'b0111, 7'b1111001}) begin
                    bad++;
                    $display("FAIL bl_hold: got %b %b want 0111 1111001", an, seg);
                end
            end
            if (i == FRAME + 1) begin
                total++;
                if ({an, seg} !== {4'b1110, 7'b0000000}) begin
                    bad++;
                    $display("FAIL bl_new: got %b %b want 1110 0000000", an, seg);
                end
            end
        end
    endtask

    task automatic test_blank();
        bit ok;
        int lows;
        blank_lz = 1'b1;
        load_digits(16'h0007);
        repeat (2) begin
            wait_fd(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL blank_sync: got no frame_done want frame_done"); end
        end
        lows = 0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge clk);
            total++;
            if (an !== 4'b1110 && an !== 4'b1111) begin
                bad++;
                $display("FAIL blank_an i=%0d: got %b want 1110 or 1111", i, an);
            end
            if (an === 4'b1110) begin
                lows++;
                total++;
                if (seg !== 7'b1111000) begin
                    bad++;
                    $display("FAIL blank_seg i=%0d: got %b want 1111000", i, seg);
                end
            end else begin
                total++;
                if ({seg, dp} !== 8'hFF) begin
                    bad++;
                    $display("FAIL blank_dark i=%0d: got %b %b want 1111111 1", i, seg, dp);
                end
            end
        end
        total++;
        if (lows != 2 * DIV) begin
            bad++;
            $display("FAIL blank_slot_count: got %0d want %0d", lows, 2 * DIV);
        end
    endtask

    task automatic test_dash();
        bit ok;
        int lows;
        blank_lz = 1'b0;
        load_digits(16'h000C);
        repeat (2) begin
            wait_fd(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL dash_sync: got no frame_done want frame_done"); end
        end
        lows = 0;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_done} !== {m_out, m_fd}) begin
                bad++;
                $display("FAIL dash_model i=%0d: got %b %b %b %b want %b %b %b %b", i, an, seg, dp,
                         frame_done, m_out[11:8], m_out[7:1], m_out[0], m_fd);
            end
            if (an === 4'b1110) begin
                lows++;
                total++;
                if (seg !== 7'b0111111) begin
                    bad++;
                    $display("FAIL dash_seg i=%0d: got %b want 0111111", i, seg);
                end
            end
        end
        total++;
        if (lows != DIV) begin
            bad++;
            $display("FAIL dash_slot_count: got %0d want %0d", lows, DIV);
        end
    endtask

    task automatic test_dp();
        bit ok;
        blank_lz = 1'b0;
        dp_en = 1'b1;
        load_digits(16'h1234);
        repeat (2) begin
            wait_fd(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL dp_sync: got no frame_done want frame_done"); end
        end
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            total++;
            if ((dp === 1'b0) !== (an === 4'b1011)) begin
                bad++;
                $display("FAIL dp_slot i=%0d: got dp=%b an=%b want dp low only with an=1011", i, dp, an);
            end
        end
        blank_lz = 1'b1;
        load_digits(16'h0005);
        repeat (2) begin
            wait_fd(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL dp_sync2: got no frame_done want frame_done"); end
        end
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            total++;
            if (dp !== 1'b1) begin
                bad++;
                $display("FAIL dp_blanked i=%0d: got dp=%b an=%b want dp=1", i, dp, an);
            end
        end
        dp_en = 1'b0;
        blank_lz = 1'b0;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        wait_fd(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_sync: got no frame_done want frame_done"); end
        repeat (3) @(negedge clk);
        load_digits(16'h8888);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({an, seg, dp, frame_done} !== 13'b1111_1111111_1_0) begin
            bad++;
            $display("FAIL rst_mid_async: got %b %b %b %b want 1111 1111111 1 0", an, seg, dp, frame_done);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 2 * FRAME + 2; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_done} !== {m_out, m_fd}) begin
                bad++;
                $display("FAIL rst_model i=%0d: got %b %b %b %b want %b %b %b %b", i, an, seg, dp,
                         frame_done, m_out[11:8], m_out[7:1], m_out[0], m_fd);
            end
            if (an === 4'b1110) begin
                total++;
                if (seg !== 7'b1000000) begin
                    bad++;
                    $display("FAIL rst_pending_lost i=%0d: got %b want 1000000", i, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_done} !== {m_out, m_fd}) begin
                bad++;
                $display("FAIL rand_model i=%0d: got %b %b %b %b want %b %b %b %b", i, an, seg, dp,
                         frame_done, m_out[11:8], m_out[7:1], m_out[0], m_fd);
            end
            total++;
            if ($countones(~an) > 1) begin
                bad++;
                $display("FAIL rand_onehot i=%0d: got an=%b want at most one low", i, an);
            end
            for (int k = 0; k < 4; k++)
                d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            load = ($urandom_range(0, 9) == 0);
            if (load) digs = d;
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 29) == 0) dp_en = ~dp_en;
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_load_midframe();
        test_boundary_load();
        test_blank();
        test_dash();
        test_dp();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit is displayed; legal range 2..2^20.
REQ-002 Parameter DP_DIGIT, default 2, digit position (0=ones..3=thousands) whose decimal point dp_en drives.
REQ-003 clk  input  1  single system clock; all state is rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 thos, hund, tens, ones  input  4 each  BCD digits from the binary-to-BCD stage.
REQ-006 load  input  1  one-cycle strobe; captures the four digits into a shadow register.
REQ-007 blank_lz  input  1  leading-zero blanking enable; sampled every cycle.
REQ-008 dp_en  input  1  lights the decimal point on digit DP_DIGIT; sampled every cycle.
REQ-009 an  output  4  active-low anode enables; an[i] drives digit i.
REQ-010 seg  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  active-low decimal point.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler counts 0..REFRESH_DIV-1 and wraps; tick asserts in the cycle the count equals REFRESH_DIV-1.
REQ-014 Digit index idx (2 bits) advances 0->1->2->3->0 on each tick only.
REQ-015 Frame boundary: tick while idx==3; frame_done asserts in the following cycle for exactly one cycle.
REQ-016 load writes all four digits into shadow and sets pending; a later load before the boundary overwrites shadow.
REQ-017 At a frame boundary with pending=1, shadow copies into the active register and pending clears; displayed digits change only at boundaries, never mid-frame.
REQ-018 load coincident with a boundary: the boundary copies the pre-load shadow, the new value enters shadow, pending stays 1 and the new value applies at the next boundary.
REQ-019 Decode: 0-9 give standard patterns (0=1000000, 1=1111001, 4=0011001, 7=1111000, 8=0000000); values 10-15 give "-" (0111111).
REQ-020 Blanking with blank_lz=1: thousands blank if active thos==0; hundreds blank if thos and hund are 0; tens blank if thos, hund and tens are 0; ones never blank.
REQ-021 Blanked digit: its anode stays 1 for its whole slot; seg=1111111 and dp=1.
REQ-022 dp=0 only while idx==DP_DIGIT, dp_en==1 and that digit is not blanked.
REQ-023 an, seg and dp are registered: they reflect idx and active digits one cycle after idx changes; at most one an bit is 0 in any cycle.
REQ-024 Inputs are assumed synchronous to clk; no input synchronisers.

Reset
REQ-025 While reset=1, without a clock edge: prescaler=0, idx=0, shadow=0, active=0, pending=0, an=1111, seg=1111111, dp=1, frame_done=0.
REQ-026 After release, the first tick occurs REFRESH_DIV cycles later, and ones (value 0, never blanked) is driven from the first post-reset edge.
REQ-027 Reset mid-frame discards pending shadow data.

Structure
REQ-028 Package seg7_pkg holds segment-pattern constants (digits 0-9, DASH, BLANK) and the digit-position constants.
REQ-029 Combinational sub-module seg7_decode maps a 4-bit BCD value to 7-bit active-low segments; it is instantiated once, on the selected digit.

Verification (REFRESH_DIV=4, DP_DIGIT=2)
REQ-030 load {1,2,3,4} mid-frame -> unchanged until next frame_done; then the slots show ones 0011001, tens 0110000, hund 0100100, thos 1111001.
REQ-031 blank_lz=1, digits {0,0,0,7} -> only an[0] ever goes low, seg=1111000 in that slot; an=1111 in the other three slots.
REQ-032 ones=4'hC loaded -> seg=0111111 in the ones slot.
REQ-033 load asserted in the boundary cycle -> new digits appear one frame (16 cycles) later; frame_done period is exactly 16 cycles.
REQ-034 dp_en=1, digits {1,2,3,4} -> dp=0 only while an=1011; with blank_lz=1 and digits {0,0,0,5}, dp stays 1.
REQ-035 reset asserted asynchronously mid-frame -> an=1111, seg=1111111 and frame_done=0 before the next clk edge; pending data lost.
